// File: rtl/seqdet_pkg.sv
// Shared constants and elaboration-time helpers for the serial sequence detector.
// seqdet_next() is the KMP transition used to build the next-state table.
package seqdet_pkg;

    localparam int         SEQDET_DEF_LEN     = 4;
    localparam logic [3:0] SEQDET_DEF_PATTERN = 4'b1101;

    function automatic int seqdet_clog2(input int v);
        int res;
        res = 0;
        for (int r = 0; r < 31; r++) begin
            if ((1 << r) < v) res = r + 1;
        end
        return res;
    endfunction

    // pattern is right-aligned; bit len-1 is the first bit received.
    function automatic int seqdet_next(input logic [15:0] pattern, input int len,
                                       input int k, input logic x);
        logic [16:0] s;
        int          best;
        logic        ok;
        if (k < len && x == pattern[len-1-k]) return k + 1;
        s = '0;
        for (int j = 0; j < 16; j++) begin
            if (j < k) s[j] = pattern[len-1-j];
        end
        s[k] = x;
        best = 0;
        // Longest proper suffix of (prefix, x) that is also a pattern prefix.
        for (int m = 1; m <= 16; m++) begin
            if (m <= k) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if (j < m && s[k+1-m+j] != pattern[len-1-j]) ok = 1'b0;
                end
                if (ok) best = m;
            end
        end
        return best;
    endfunction

endpackage

// File: rtl/seqdet_sat_counter.sv
// 8-bit up-counter that sticks at 8'hFF; synchronous active-high reset.
module seqdet_sat_counter (
    input  logic       clk,
    input  logic       rst_i,
    input  logic       inc_i,
    output logic [7:0] cnt_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/sequence_detector.sv
// Moore serial pattern detector with overlap (KMP prefix-length state).
// Optional match counter output enabled by macro SEQDET_COUNT_EN.
module sequence_detector
    import seqdet_pkg::*;
#(
    parameter int                 PAT_LEN = SEQDET_DEF_LEN,
    parameter logic [PAT_LEN-1:0] PATTERN = SEQDET_DEF_PATTERN
) (
    input  logic       clk,
    input  logic       Nrst,
    input  logic       x,
    output logic       y
`ifdef SEQDET_COUNT_EN
    ,
    output logic [7:0] match_cnt
`endif
);

    localparam int             SW   = seqdet_clog2(PAT_LEN + 1);
    localparam logic [SW-1:0]  FULL = SW'(PAT_LEN);

    logic [SW-1:0] state;
    logic [SW-1:0] state_d;
    logic [SW-1:0] nxt_tab [0:PAT_LEN][2];

    // Transition table is pure constants; no storage is inferred.
    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_tab
        assign nxt_tab[k][0] = SW'(seqdet_next(16'(PATTERN), PAT_LEN, k, 1'b0));
        assign nxt_tab[k][1] = SW'(seqdet_next(16'(PATTERN), PAT_LEN, k, 1'b1));
    end

    always_comb begin
        state_d = '0;
        if (state <= FULL) state_d = nxt_tab[state][x];
    end

    // y is registered alongside state so it always equals (state == FULL).
    always_ff @(posedge clk) begin
        if (Nrst) begin
            state <= '0;
            y     <= 1'b0;
        end else begin
            state <= state_d;
            y     <= (state_d == FULL);
        end
    end

`ifdef SEQDET_COUNT_EN
    seqdet_sat_counter u_cnt (
        .clk   (clk),
        .rst_i (Nrst),
        .inc_i ((state_d == FULL) && !Nrst),
        .cnt_o (match_cnt)
    );
`endif

endmodule

// File: tb/tb_sequence_detector.sv
// Bench for sequence_detector (default 1101); exercises match_cnt when SEQDET_COUNT_EN is defined.
module tb_sequence_detector;

    localparam int         PAT_LEN = 4;
    localparam logic [3:0] PAT     = 4'b1101;

    logic clk;
    logic Nrst;
    logic x;
    logic y;
`ifdef SEQDET_COUNT_EN
    logic [7:0] match_cnt;
`endif

    int n_tests;
    int n_fail;

    bit hist[$];
    int exp_state;
    bit exp_y;
    int exp_cnt;

    sequence_detector #(.PAT_LEN(PAT_LEN), .PATTERN(PAT)) sd (
        .clk  (clk),
        .Nrst (Nrst),
        .x    (x),
        .y    (y)
`ifdef SEQDET_COUNT_EN
        ,
        .match_cnt (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Longest pattern prefix that is a suffix of the bits seen since reset.
    function automatic int ref_state();
        int  best;
        bit  ok;
        int  n;
        best = 0;
        n = hist.size();
        for (int k = 1; k <= PAT_LEN; k++) begin
            if (k <= n) begin
                ok = 1'b1;
                for (int j = 0; j < k; j++) begin
                    if (hist[n-k+j] != PAT[PAT_LEN-1-j]) ok = 1'b0;
                end
                if (ok) best = k;
            end
        end
        return best;
    endfunction

    task automatic drive(input logic xv, input logic rv);
        x    = xv;
        Nrst = rv;
        @(posedge clk);
        #1;
        if (rv) begin
            hist.delete();
            exp_cnt = 0;
        end else begin
            hist.push_back(xv);
            if (ref_state() == PAT_LEN && exp_cnt < 255) exp_cnt++;
        end
        exp_state = ref_state();
        exp_y     = (exp_state == PAT_LEN);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b1);
        drive(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            drive(logic'(i[0]), 1'b1);
            n_tests++;
            if (int'(sd.state) !== 0 || y !== 1'b0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: state=%0d y=%b, want state=0 y=0", i, sd.state, y);
            end
        end
`ifdef SEQDET_COUNT_EN
        n_tests++;
        if (match_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_cnt: match_cnt=%0d, want 0", match_cnt);
        end
`endif
    endtask

    task automatic test_basic();
        logic [3:0] seq;
        seq = 4'b1101;
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            drive(seq[i], 1'b0);
            n_tests++;
            if (int'(sd.state) !== exp_state || y !== exp_y) begin
                n_fail++;
                $display("FAIL basic bit%0d: state=%0d y=%b, want state=%0d y=%b",
                         3 - i, sd.state, y, exp_state, exp_y);
            end
        end
        n_tests++;
        if (int'(sd.state) !== 4 || y !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_match: state=%0d y=%b, want state=4 y=1", sd.state, y);
        end
        drive(1'b0, 1'b0);
        n_tests++;
        if (y !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_one_cycle: y=%b, want 0", y);
        end
    endtask

    task automatic test_overlap();
        logic [6:0] seq;
        int pulses;
        int first_at;
        int second_at;
        seq = 7'b1101101;
        pulses = 0;
        first_at = -1;
        second_at = -1;
        do_reset();
        for (int i = 6; i >= 0; i--) begin
            drive(seq[i], 1'b0);
            n_tests++;
            if (int'(sd.state) !== exp_state || y !== exp_y) begin
                n_fail++;
                $display("FAIL overlap bit%0d: state=%0d y=%b, want state=%0d y=%b",
                         6 - i, sd.state, y, exp_state, exp_y);
            end
            if (y === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = 6 - i;
                else second_at = 6 - i;
            end
        end
        n_tests++;
        if (pulses !== 2 || second_at - first_at !== 3) begin
            n_fail++;
            $display("FAIL overlap_pulses: pulses=%0d gap=%0d, want 2 gap 3",
                     pulses, second_at - first_at);
        end
`ifdef SEQDET_COUNT_EN
        n_tests++;
        if (match_cnt !== 8'd2) begin
            n_fail++;
            $display("FAIL overlap_cnt: match_cnt=%0d, want 2", match_cnt);
        end
`endif
    endtask

    task automatic test_fallback();
        logic [5:0] seq;
        seq = 6'b111101;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            drive(seq[i], 1'b0);
            n_tests++;
            if (int'(sd.state) !== exp_state || y !== exp_y) begin
                n_fail++;
                $display("FAIL fallback bit%0d: state=%0d y=%b, want state=%0d y=%b",
                         5 - i, sd.state, y, exp_state, exp_y);
            end
            if (i >= 2 && i <= 4) begin
                n_tests++;
                if (int'(sd.state) !== 2) begin
                    n_fail++;
                    $display("FAIL fallback_hold bit%0d: state=%0d, want 2", 5 - i, sd.state);
                end
            end
        end
        n_tests++;
        if (y !== 1'b1) begin
            n_fail++;
            $display("FAIL fallback_end: y=%b, want 1", y);
        end
    endtask

    task automatic test_mid_reset();
        int seen_y;
        seen_y = 0;
        do_reset();
        drive(1'b1, 1'b0);
        if (y === 1'b1) seen_y++;
        drive(1'b1, 1'b0);
        if (y === 1'b1) seen_y++;
        drive(1'b0, 1'b0);
        if (y === 1'b1) seen_y++;
        drive(1'b1, 1'b1);
        if (y === 1'b1) seen_y++;
        n_tests++;
        if (int'(sd.state) !== 0) begin
            n_fail++;
            $display("FAIL mid_reset_clear: state=%0d, want 0", sd.state);
        end
        drive(1'b1, 1'b0);
        if (y === 1'b1) seen_y++;
        n_tests++;
        if (int'(sd.state) !== 1 || seen_y !== 0) begin
            n_fail++;
            $display("FAIL mid_reset: state=%0d y_pulses=%0d, want state=1 y_pulses=0",
                     sd.state, seen_y);
        end
    endtask

    task automatic test_random();
        int errs;
        logic rv;
        errs = 0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rv = ($urandom_range(0, 49) == 0);
            // Bias toward 1s so matches occur often.
            drive(logic'($urandom_range(0, 9) < 6), rv);
            n_tests++;
            if (int'(sd.state) !== exp_state || y !== exp_y) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random cyc%0d: state=%0d y=%b, want state=%0d y=%b",
                             i, sd.state, y, exp_state, exp_y);
            end
`ifdef SEQDET_COUNT_EN
            n_tests++;
            if (int'(match_cnt) !== exp_cnt) begin
                n_fail++;
                errs++;
                if (errs < 10)
                    $display("FAIL random_cnt cyc%0d: match_cnt=%0d, want %0d",
                             i, match_cnt, exp_cnt);
            end
`endif
        end
    endtask

`ifdef SEQDET_COUNT_EN
    task automatic test_saturation();
        logic [3:0] seq;
        int pulses;
        seq = 4'b1101;
        pulses = 0;
        do_reset();
        for (int r = 0; r < 300; r++) begin
            for (int i = 3; i >= 0; i--) begin
                drive(seq[i], 1'b0);
                if (y === 1'b1) pulses++;
            end
        end
        n_tests++;
        if (match_cnt !== 8'hFF || exp_cnt !== 255) begin
            n_fail++;
            $display("FAIL saturation_cnt: match_cnt=%0d, want 255", match_cnt);
        end
        n_tests++;
        if (pulses !== 300) begin
            n_fail++;
            $display("FAIL saturation_pulses: pulses=%0d, want 300", pulses);
        end
    endtask
`endif

    initial begin
        n_tests = 0;
        n_fail  = 0;
        exp_cnt = 0;
        x       = 1'b0;
        Nrst    = 1'b1;
        test_reset();
        test_basic();
        test_overlap();
        test_fallback();
        test_mid_reset();
        test_random();
`ifdef SEQDET_COUNT_EN
        test_saturation();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
